// File: rtl/timestamp_grey_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timestamp_grey_ctrl (with helper grey_from_binary)
// Purpose  : Free-running timestamp counter published as registered Gray
//            code. Arbitrates absolute load and signed adjust, and holds
//            grey_valid low for a settle window after any non-unit step.
// Revision : 1.0 - initial release
// ============================================================================

// Binary to Gray converter: MSB passes through, bit i = b[i] ^ b[i+1].
module grey_from_binary #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] grey
);
    assign grey[WIDTH-1] = bin[WIDTH-1];

    genvar i;
    generate
        for (i = 0; i < WIDTH - 1; i++) begin : g_bits
            assign grey[i] = bin[i] ^ bin[i+1];
        end
    endgenerate
endmodule

module timestamp_grey_ctrl #(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ack,
    input  logic             adj_req,
    input  logic [WIDTH-1:0] adj_offset,
    output logic             adj_ack,
    output logic [WIDTH-1:0] count_binary,
    output logic [WIDTH-1:0] count_grey,
    output logic             grey_valid,
    output logic             discontinuity,
    output logic             busy
);
    localparam int unsigned c_SETTLE_W = (SETTLE_CYCLES < 2) ? 2 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_INIT = c_SETTLE_W'(SETTLE_CYCLES);
    localparam logic c_RR_LOAD = 1'b0;
    localparam logic c_RR_ADJ  = 1'b1;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_SETTLE_W-1:0] r_settle;
    logic [c_SETTLE_W-1:0] w_settle_next;
    logic                  r_rr_last;
    logic                  w_rr_next;
    logic [WIDTH-1:0]      r_count;
    logic [WIDTH-1:0]      r_grey;
    logic                  r_load_ack;
    logic                  r_adj_ack;
    logic                  r_disc;

    logic                  w_run;
    logic                  w_grant_load;
    logic                  w_grant_adj;
    logic [WIDTH-1:0]      w_inc;
    logic [WIDTH-1:0]      w_count_next;
    logic [WIDTH-1:0]      w_grey_next;

    // Requests are only looked at in RUN; on a tie the side that did not
    // win last time is granted.
    assign w_run        = (r_state == ST_RUN);
    assign w_grant_load = w_run & load_req & (~adj_req  | (r_rr_last == c_RR_ADJ));
    assign w_grant_adj  = w_run & adj_req  & (~load_req | (r_rr_last == c_RR_LOAD));
    assign w_inc        = WIDTH'(enable);

    // Next counter value; a load overrides the enable increment.
    always_comb begin
        w_count_next = r_count + w_inc;
        if (w_grant_load) begin
            w_count_next = load_value;
        end else if (w_grant_adj) begin
            w_count_next = r_count + adj_offset + w_inc;
        end
    end

    // Gray is taken from the next value so binary and Gray land on one edge.
    grey_from_binary #(
        .WIDTH (WIDTH)
    ) u_grey (
        .bin  (w_count_next),
        .grey (w_grey_next)
    );

    // Next-state logic: any grant opens a settle window; the window closes
    // on the edge where the counter reads 1.
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        w_rr_next     = r_rr_last;
        case (r_state)
            ST_RUN: begin
                if (w_grant_load) begin
                    w_state_next  = ST_SETTLE;
                    w_settle_next = c_SETTLE_INIT;
                    w_rr_next     = c_RR_LOAD;
                end else if (w_grant_adj) begin
                    w_state_next  = ST_SETTLE;
                    w_settle_next = c_SETTLE_INIT;
                    w_rr_next     = c_RR_ADJ;
                end
            end
            ST_SETTLE: begin
                if (r_settle <= c_SETTLE_W'(1)) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_settle_next = r_settle - c_SETTLE_W'(1);
                end
            end
            default: begin
                w_state_next  = ST_SETTLE;
                w_settle_next = c_SETTLE_INIT;
            end
        endcase
    end

    // State, arbitration history and settle counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_SETTLE;
            r_settle  <= c_SETTLE_INIT;
            r_rr_last <= c_RR_ADJ;
        end else begin
            r_state   <= w_state_next;
            r_settle  <= w_settle_next;
            r_rr_last <= w_rr_next;
        end
    end

    // Counter, Gray pair and one-cycle handshake/discontinuity pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count    <= '0;
            r_grey     <= '0;
            r_load_ack <= 1'b0;
            r_adj_ack  <= 1'b0;
            r_disc     <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_grey     <= w_grey_next;
            r_load_ack <= w_grant_load;
            r_adj_ack  <= w_grant_adj;
            r_disc     <= w_grant_load | w_grant_adj;
        end
    end

    assign count_binary  = r_count;
    assign count_grey    = r_grey;
    assign load_ack      = r_load_ack;
    assign adj_ack       = r_adj_ack;
    assign discontinuity = r_disc;
    assign busy          = (r_state == ST_SETTLE);
    assign grey_valid    = (r_state == ST_RUN);
endmodule
`default_nettype wire

// File: tb/tb_timestamp_grey_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_timestamp_grey_ctrl
// Purpose  : Directed table-driven bench for timestamp_grey_ctrl
//            (WIDTH=8, SETTLE_CYCLES=4) plus multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timestamp_grey_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             resetn;
    logic             enable;
    logic             load_req;
    logic [WIDTH-1:0] load_value;
    logic             load_ack;
    logic             adj_req;
    logic [WIDTH-1:0] adj_offset;
    logic             adj_ack;
    logic [WIDTH-1:0] count_binary;
    logic [WIDTH-1:0] count_grey;
    logic             grey_valid;
    logic             discontinuity;
    logic             busy;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       en;
        logic       lr;
        logic [7:0] lv;
        logic       ar;
        logic [7:0] ao;
        logic [7:0] c;
        logic [7:0] g;
        logic       v;
        logic       b;
        logic       la;
        logic       aa;
        logic       d;
    } vec_t;

    vec_t tbl[$];

    timestamp_grey_ctrl #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .load_req      (load_req),
        .load_value    (load_value),
        .load_ack      (load_ack),
        .adj_req       (adj_req),
        .adj_offset    (adj_offset),
        .adj_ack       (adj_ack),
        .count_binary  (count_binary),
        .count_grey    (count_grey),
        .grey_valid    (grey_valid),
        .discontinuity (discontinuity),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gray8(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic cmp(input string nm, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] c, input logic [7:0] g,
                             input logic v, input logic b, input logic la,
                             input logic aa, input logic d);
        cmp({tag, ".count"}, count_binary, c);
        cmp({tag, ".grey"},  count_grey,   g);
        cmp({tag, ".valid"}, grey_valid,   v);
        cmp({tag, ".busy"},  busy,         b);
        cmp({tag, ".lack"},  load_ack,     la);
        cmp({tag, ".aack"},  adj_ack,      aa);
        cmp({tag, ".disc"},  discontinuity, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic lr, input logic [7:0] lv,
                       input logic ar, input logic [7:0] ao, input logic [7:0] c,
                       input logic [7:0] g, input logic v, input logic b,
                       input logic la, input logic aa, input logic d);
        vec_t t;
        t.en = en; t.lr = lr; t.lv = lv; t.ar = ar; t.ao = ao;
        t.c = c; t.g = g; t.v = v; t.b = b; t.la = la; t.aa = aa; t.d = d;
        tbl.push_back(t);
    endtask

    // Four settle cycles after a grant, requests idle; valid returns on the 4th.
    task automatic settle(input string tag, input logic [7:0] start, input logic en);
        logic [7:0] c;
        c = start;
        for (int i = 1; i <= 4; i++) begin
            tick();
            c = c + 8'(en);
            check_all(tag, c, gray8(c), (i == 4), (i != 4), 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; load_req = 1'b0; load_value = '0;
        adj_req = 1'b0; adj_offset = '0;

        //   en lr lv     ar ao     count  grey   v  b  la aa d
        // Post-reset count-up; valid rises on the 4th edge.
        add(1, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'h02, 8'h03, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'h03, 8'h02, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'h04, 8'h06, 1, 0, 0, 0, 0);
        // Load 0xFE, wrap during settle.
        add(1, 1, 8'hFE, 0, 8'h00, 8'hFE, 8'h81, 0, 1, 1, 0, 1);
        add(1, 0, 8'h00, 0, 8'h00, 8'hFF, 8'h80, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'h02, 8'h03, 1, 0, 0, 0, 0);
        // Load 0xFA, then wrap FF->00 while valid: no discontinuity.
        add(1, 1, 8'hFA, 0, 8'h00, 8'hFA, 8'h87, 0, 1, 1, 0, 1);
        add(1, 0, 8'h00, 0, 8'h00, 8'hFB, 8'h86, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'hFC, 8'h82, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'hFD, 8'h83, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'hFE, 8'h81, 1, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'hFF, 8'h80, 1, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 1, 0, 0, 0, 0);
        // Enable low holds.
        add(0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 1, 0, 0, 0, 0);
        // Load of the current value is still a discontinuity.
        add(1, 1, 8'h01, 0, 8'h00, 8'h01, 8'h01, 0, 1, 1, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 1, 0, 0, 0, 0);

        // Reset state.
        tick();
        tick();
        check_all("reset", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        enable = 1'b1;

        foreach (tbl[k]) begin
            enable = tbl[k].en; load_req = tbl[k].lr; load_value = tbl[k].lv;
            adj_req = tbl[k].ar; adj_offset = tbl[k].ao;
            tick();
            check_all($sformatf("vec%0d", k), tbl[k].c, tbl[k].g, tbl[k].v, tbl[k].b,
                      tbl[k].la, tbl[k].aa, tbl[k].d);
        end
        load_req = 1'b0; adj_req = 1'b0; enable = 1'b0;

        // Adjust with enable low: 0x01 + 0x2F -> 0x30.
        adj_req = 1'b1; adj_offset = 8'h2F;
        tick();
        check_all("adj_en0", 8'h30, gray8(8'h30), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        adj_req = 1'b0;
        settle("adj_en0_settle", 8'h30, 1'b0);

        // Adjust by -1 with enable high: count holds, still a discontinuity.
        adj_req = 1'b1; adj_offset = 8'hFF; enable = 1'b1;
        tick();
        check_all("adj_m1", 8'h30, gray8(8'h30), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        adj_req = 1'b0; enable = 1'b0;
        settle("adj_m1_settle", 8'h30, 1'b0);

        // Move to 0x20 with an adjust so ADJ is the last winner.
        adj_req = 1'b1; adj_offset = 8'hF0;
        tick();
        check_all("adj_to20", 8'h20, gray8(8'h20), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        adj_req = 1'b0;
        settle("adj_to20_settle", 8'h20, 1'b0);

        // Simultaneous requests: load first, adjust held through settle.
        load_req = 1'b1; load_value = 8'h40; adj_req = 1'b1; adj_offset = 8'h10; enable = 1'b1;
        tick();
        check_all("tie_load", 8'h40, gray8(8'h40), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        load_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_all("tie_wait", 8'(8'h40 + i), gray8(8'(8'h40 + i)), (i == 4), (i != 4),
                      1'b0, 1'b0, 1'b0);
            cmp("tie_wait.complement", busy ^ grey_valid, 1);
        end
        tick();
        check_all("tie_adj", 8'h55, gray8(8'h55), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        adj_req = 1'b0; enable = 1'b0;
        settle("tie_adj_settle", 8'h55, 1'b0);

        // Reset mid-settle with a load pending.
        adj_req = 1'b1; adj_offset = 8'h01;
        tick();
        check_all("pre_rst_adj", 8'h56, gray8(8'h56), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        adj_req = 1'b0; load_req = 1'b1; load_value = 8'h77;
        tick();
        check_all("pre_rst_settle", 8'h56, gray8(8'h56), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check_all("mid_rst", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("mid_rst_hold", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_all("post_rst", 8'h00, 8'h00, (i == 4), (i != 4), 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_all("post_rst_load", 8'h77, gray8(8'h77), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        load_req = 1'b0;
        settle("post_rst_settle", 8'h77, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
